// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters with round-robin arbitration and packet locking.
//
// Ports:
//   clock_i       system clock
//   reset_i       asynchronous, active-high reset
//   req_valid_i   per-requester byte valid
//   req_data_i    per-requester byte, requester i in bits [8i+7:8i]
//   req_last_i    per-requester end-of-packet flag
//   req_ready_o   one-hot accept strobe (byte moves when valid & ready)
//   grant_o       one-hot current owner, zero when unowned
//   tx_data_o     byte to the transmitter, held until the next accept
//   tx_write_o    single-cycle transmitter write strobe
//   tx_busy_i     transmitter busy flag
//
// Optional feature macro: UART_TX_ARB_LOCK_TIMEOUT_EN
//   When defined, a locked owner that stalls in ARB without a valid byte for
//   LOCK_TIMEOUT cycles loses the lock, and arbitration resumes at owner+1.
//   When undefined, the lock is held until the owner sends its last byte.

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PTR_WIDTH    = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_write_o,
    input  logic                   tx_busy_i
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << PTR_WIDTH) < NUM_REQ ||
        LOCK_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ARB,
        WRITE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic [PTR_WIDTH-1:0] owner_q, owner_d;
    logic                 lock_q, lock_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_write_q, tx_write_d;

    // Round-robin successor, wrapping at NUM_REQ rather than 2**PTR_WIDTH.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(
        input logic [PTR_WIDTH-1:0] p
    );
        if (int'(p) >= NUM_REQ - 1) begin
            return '0;
        end
        return p + PTR_WIDTH'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(
        input logic [PTR_WIDTH-1:0] p
    );
        return NUM_REQ'(1) << p;
    endfunction

    // ------------------------------------------------------------------
    // Winner scan: first eligible valid starting at ptr, wrapping mod
    // NUM_REQ. A held lock narrows the eligible set to the owner alone.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [PTR_WIDTH-1:0] win;
    logic                 accept;
    logic [7:0]           win_data;
    logic                 win_last;

    always_comb begin
        int idx;
        idx      = 0;
        eligible = req_valid_i;
        if (lock_q) begin
            eligible = req_valid_i & onehot(owner_q);
        end
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = PTR_WIDTH'(idx);
            end
        end
    end

    assign accept   = (state_q == ARB) && !tx_busy_i && found;
    assign win_data = req_data_i[8*int'(win) +: 8];
    assign win_last = req_last_i[win];

    assign req_ready_o = accept ? onehot(win) : '0;

    // ------------------------------------------------------------------
    // Lock timeout (optional). Counts owner-stall cycles in ARB.
    // ------------------------------------------------------------------
    logic expire;

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    assign stall  = lock_q && (state_q == ARB) && !req_valid_i[owner_q];
    assign expire = stall && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept || expire) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state and registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        last_d     = last_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_write_d = 1'b0;

        unique case (state_q)
            ARB: begin
                if (accept) begin
                    tx_data_d  = win_data;
                    grant_d    = onehot(win);
                    owner_d    = win;
                    last_d     = win_last;
                    tx_write_d = 1'b1;
                    state_d    = WRITE;
                end else if (expire) begin
                    lock_d  = 1'b0;
                    grant_d = '0;
                    ptr_d   = next_ptr(owner_q);
                end
            end
            WRITE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ARB;
                    if (last_q) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        ptr_d   = next_ptr(owner_q);
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_q     <= 1'b0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
        end
    end

    assign grant_o    = grant_q;
    assign tx_data_o  = tx_data_q;
    assign tx_write_o = tx_write_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter.
// Includes a simple transmitter model that stays busy per written byte.

module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_CYC = 20;

    logic             clock_i = 1'b0;
    logic             reset_i = 1'b1;
    logic [N-1:0]     req_valid_i = '0;
    logic [8*N-1:0]   req_data_i = '0;
    logic [N-1:0]     req_last_i = '0;
    logic [N-1:0]     req_ready_o;
    logic [N-1:0]     grant_o;
    logic [7:0]       tx_data_o;
    logic             tx_write_o;
    logic             tx_busy_i;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .PTR_WIDTH    (2),
        .LOCK_TIMEOUT (1024)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .tx_data_o   (tx_data_o),
        .tx_write_o  (tx_write_o),
        .tx_busy_i   (tx_busy_i)
    );

    always #5 clock_i = ~clock_i;

    // Transmitter model.
    int   tx_cnt = 0;
    logic force_busy = 1'b1;

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tx_cnt <= 0;
        end else if (tx_write_o) begin
            tx_cnt <= BUSY_CYC;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end
    end

    assign tx_busy_i = force_busy | (tx_cnt != 0);

    // Requester byte queues {last, data} and expected-output scoreboard.
    logic [8:0] rq [N][$];

    typedef struct packed {
        logic [7:0]   d;
        logic [N-1:0] g;
    } exp_t;

    exp_t expq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req,
                     $time);
        end
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                h = rq[i][0];
                req_valid_i[i]        = 1'b1;
                req_data_i[8*i +: 8]  = h[7:0];
                req_last_i[i]         = h[8];
            end else begin
                req_valid_i[i]        = 1'b0;
                req_data_i[8*i +: 8]  = 8'h00;
                req_last_i[i]         = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [N-1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        expq.push_back(e);
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) return 1'b1;
        end
        return (expq.size() > 0) || tx_busy_i;
    endfunction

    // Monitor: pops the scoreboard on each write strobe and checks strobe
    // shape against the busy handshake.
    logic prev_wr = 1'b0;
    logic armed   = 1'b0;
    logic rose    = 1'b0;
    logic fell    = 1'b0;
    exp_t mon_e;

    always @(negedge clock_i) begin
        if (reset_i) begin
            prev_wr = 1'b0;
            armed   = 1'b0;
            rose    = 1'b0;
            fell    = 1'b0;
        end else begin
            if (tx_busy_i) rose = 1'b1;
            else if (rose) fell = 1'b1;
            if (req_ready_o != '0) begin
                chk("ready_onehot", $countones(req_ready_o), 1);
            end
            if (tx_write_o) begin
                chk("strobe_single", {31'b0, prev_wr}, 0);
                if (armed) begin
                    chk("busy_between", {31'b0, rose && fell}, 1);
                end
                armed = 1'b1;
                rose  = 1'b0;
                fell  = 1'b0;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: data %0h grant %0h",
                             tx_data_o, grant_o);
                end else begin
                    mon_e = expq.pop_front();
                    chk("tx_data", tx_data_o, mon_e.d);
                    chk("grant", grant_o, mon_e.g);
                end
                for (int i = 0; i < N; i++) begin
                    if (grant_o[i] && rq[i].size() > 0) begin
                        void'(rq[i].pop_front());
                    end
                end
                drive();
            end
            prev_wr = tx_write_o;
        end
    end

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            @(negedge clock_i);
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still pending after %0d cycles",
                     nm, n);
        end
        repeat (3) @(negedge clock_i);
    endtask

    task automatic wait_write(input string nm);
        int n;
        n = 0;
        while (!tx_write_o && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_nowrite: no strobe in %0d cycles", nm, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        drive();
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        int n;

        // Reset state, with the transmitter still busy after reset.
        drive();
        repeat (3) @(negedge clock_i);
        chk("rst_grant", grant_o, 0);
        chk("rst_write", tx_write_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_ready", req_ready_o, 0);
        reset_i = 1'b0;

        // T1: nothing accepted while busy; then one byte.
        rq[0].push_back({1'b1, 8'h55});
        push_exp(8'h55, 4'b0001);
        drive();
        bad = 1'b0;
        repeat (100) begin
            @(negedge clock_i);
            if (req_ready_o != '0 || tx_write_o) bad = 1'b1;
        end
        chk("t1_quiet_while_busy", {31'b0, bad}, 0);
        force_busy = 1'b0;
        #1;
        chk("t1_ready_pulse", req_ready_o, 4'b0001);
        @(negedge clock_i);
        chk("t1_write_next", tx_write_o, 1);
        repeat (5) @(negedge clock_i);
        chk("t1_grant_held", grant_o, 4'b0001);
        chk("t1_data_held", tx_data_o, 8'h55);
        wait_idle("t1", 200);
        chk("t1_grant_free", grant_o, 0);

        // T2: all four valid, single-byte packets, pointer rotation.
        do_reset();
        rq[0].push_back({1'b1, 8'hA0});
        rq[0].push_back({1'b1, 8'hA0});
        rq[1].push_back({1'b1, 8'hA1});
        rq[2].push_back({1'b1, 8'hA2});
        rq[3].push_back({1'b1, 8'hA3});
        push_exp(8'hA0, 4'b0001);
        push_exp(8'hA1, 4'b0010);
        push_exp(8'hA2, 4'b0100);
        push_exp(8'hA3, 4'b1000);
        push_exp(8'hA0, 4'b0001);
        drive();
        wait_idle("t2", 500);

        // T3: req1 3-byte packet stays contiguous; then req2 before req0.
        do_reset();
        rq[1].push_back({1'b0, 8'hB0});
        rq[1].push_back({1'b0, 8'hB1});
        rq[1].push_back({1'b1, 8'hB2});
        push_exp(8'hB0, 4'b0010);
        push_exp(8'hB1, 4'b0010);
        push_exp(8'hB2, 4'b0010);
        push_exp(8'hD0, 4'b0100);
        push_exp(8'hC0, 4'b0001);
        drive();
        wait_write("t3");
        @(negedge clock_i);
        rq[0].push_back({1'b1, 8'hC0});
        rq[2].push_back({1'b1, 8'hD0});
        drive();
        wait_idle("t3", 500);

        // T4: locked req3 stalls with req0 waiting.
        do_reset();
        rq[3].push_back({1'b0, 8'hE0});
        push_exp(8'hE0, 4'b1000);
        drive();
        wait_idle("t4a", 200);
        rq[0].push_back({1'b1, 8'hF0});
        drive();
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        push_exp(8'hF0, 4'b0001);
        n = 0;
        while (grant_o != 4'b0000 && n < 1200) begin
            @(negedge clock_i);
            n++;
        end
        chk("t4_release_window", {31'b0, n >= 1010 && n <= 1030}, 1);
        wait_idle("t4b", 200);
`else
        bad = 1'b0;
        n = 0;
        repeat (5000) begin
            @(negedge clock_i);
            if (grant_o != 4'b1000 || tx_write_o) bad = 1'b1;
            n++;
        end
        chk("t4_lock_held", {31'b0, bad}, 0);
        rq[3].push_back({1'b1, 8'hE1});
        push_exp(8'hE1, 4'b1000);
        push_exp(8'hF0, 4'b0001);
        drive();
        wait_idle("t4b", 300);
`endif

        // T5: async reset during WAIT_DONE, pointer returns to 0.
        do_reset();
        rq[1].push_back({1'b1, 8'h61});
        push_exp(8'h61, 4'b0010);
        drive();
        wait_idle("t5a", 200);
        rq[2].push_back({1'b1, 8'h62});
        push_exp(8'h62, 4'b0100);
        drive();
        wait_write("t5");
        n = 0;
        while (!tx_busy_i && n < 20) begin
            @(negedge clock_i);
            n++;
        end
        repeat (3) @(negedge clock_i);
        chk("t5_pre_data", tx_data_o, 8'h62);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t5_rst_grant", grant_o, 0);
        chk("t5_rst_write", tx_write_o, 0);
        chk("t5_rst_data", tx_data_o, 0);
        chk("t5_rst_ready", req_ready_o, 0);
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        drive();
        @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        rq[0].push_back({1'b1, 8'h70});
        rq[2].push_back({1'b1, 8'h72});
        push_exp(8'h70, 4'b0001);
        push_exp(8'h72, 4'b0100);
        drive();
        wait_idle("t5b", 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
